// File: rtl/sigma_pkg.sv
// Shared types and encodings for the SigmaCore multi-cycle RV32I control path.
package sigma_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_LUI       = 4'd8,
    S_AUIPC     = 4'd9,
    S_ALU_WB    = 4'd10,
    S_BRANCH    = 4'd11,
    S_JAL       = 4'd12,
    S_JALR      = 4'd13,
    S_TRAP      = 4'd14
  } mc_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_SRC_ALU      = 2'b00;
  localparam logic [1:0] PC_SRC_ALU_OUT  = 2'b01;
  localparam logic [1:0] PC_SRC_ALU_LSB0 = 2'b10;
  localparam logic [1:0] PC_SRC_TRAP     = 2'b11;

  localparam logic [1:0] MEM_TO_REG_ALU_OUT = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR     = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC      = 2'b10;

  localparam logic [1:0] ALU_SRC_A_REG    = 2'b00;
  localparam logic [1:0] ALU_SRC_A_PC     = 2'b01;
  localparam logic [1:0] ALU_SRC_A_OLD_PC = 2'b10;
  localparam logic [1:0] ALU_SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] ALU_SRC_B_REG  = 2'b00;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'b10;

  localparam logic [2:0] IMM_TYPE_NONE = 3'd0;
  localparam logic [2:0] IMM_TYPE_I    = 3'd1;
  localparam logic [2:0] IMM_TYPE_S    = 3'd2;
  localparam logic [2:0] IMM_TYPE_B    = 3'd3;
  localparam logic [2:0] IMM_TYPE_U    = 3'd4;
  localparam logic [2:0] IMM_TYPE_J    = 3'd5;

  localparam logic [1:0] ALU_OP_TYPE_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_TYPE_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_TYPE_FUNCT = 2'b10;

  localparam logic [1:0] TRAP_CAUSE_ILLEGAL = 2'b00;
  localparam logic [1:0] TRAP_CAUSE_TIMEOUT = 2'b01;

  typedef struct packed {
    logic       pc_write;
    logic       old_pc_write;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_a_write;
    logic       reg_b_write;
    logic       alu_out_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       instr_retired;
    logic       trap;
    logic [1:0] pc_source;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [1:0] alu_op_type;
    logic [1:0] trap_cause;
  } mc_ctrl_t;

  // States that drive a memory strobe and may stall on mem_ready.
  function automatic logic is_mem_state(mc_state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mc_wait_watchdog.sv
// Consecutive wait-cycle counter; flags the last wait cycle before a timeout trap.
module mc_wait_watchdog #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic count_en,
  input  logic clear,
  output logic terminal
);

  // Terminal when the count is one short of all-ones: this wait cycle is the 2^W-1'th.
  localparam logic [TIMEOUT_W-1:0] TermCount = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  assign terminal = (count_q == TermCount);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute and drives every
// datapath enable and mux select, with memory wait states, watchdog and traps.
module mc_control_fsm
  import sigma_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned TIMEOUT_W     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       old_pc_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       reg_a_write,
  output logic       reg_b_write,
  output logic       alu_out_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic [1:0] pc_source,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [1:0] alu_op_type,
  output logic       instr_retired,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  mc_state_e  state_q, state_d;
  logic       run_q;
  logic [1:0] cause_q, cause_d;
  logic       ready, waiting, wd_terminal, timeout;
  mc_ctrl_t   ctrl;

  assign ready   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign waiting = run_q && is_mem_state(state_q) && !ready;
  // Ready on the terminal cycle suppresses the timeout because waiting is then low.
  assign timeout = waiting && wd_terminal;

  mc_wait_watchdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .count_en(waiting),
    .clear   (!waiting || timeout),
    .terminal(wd_terminal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      state_q <= S_FETCH;
      cause_q <= TRAP_CAUSE_ILLEGAL;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    if (run_q) begin
      unique case (state_q)
        S_FETCH: begin
          if (timeout) begin
            state_d = S_TRAP;
            cause_d = TRAP_CAUSE_TIMEOUT;
          end else if (ready) begin
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          case (opcode)
            OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
            OPC_OP:              state_d = S_EXEC_R;
            OPC_OP_IMM:          state_d = S_EXEC_I;
            OPC_BRANCH:          state_d = S_BRANCH;
            OPC_JAL:             state_d = S_JAL;
            OPC_JALR:            state_d = S_JALR;
            OPC_LUI:             state_d = S_LUI;
            OPC_AUIPC:           state_d = S_AUIPC;
            default: begin
              state_d = S_TRAP;
              cause_d = TRAP_CAUSE_ILLEGAL;
            end
          endcase
        end
        S_MEM_ADDR: state_d = (opcode == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ: begin
          if (timeout) begin
            state_d = S_TRAP;
            cause_d = TRAP_CAUSE_TIMEOUT;
          end else if (ready) begin
            state_d = S_MEM_WB;
          end
        end
        S_MEM_WRITE: begin
          if (timeout) begin
            state_d = S_TRAP;
            cause_d = TRAP_CAUSE_TIMEOUT;
          end else if (ready) begin
            state_d = S_FETCH;
          end
        end
        S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_d = S_ALU_WB;
        S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_TRAP: state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl = '0;
    if (run_q) begin
      unique case (state_q)
        S_FETCH: begin
          ctrl.mem_read     = 1'b1;
          ctrl.i_or_d       = 1'b0;
          ctrl.alu_src_a    = ALU_SRC_A_PC;
          ctrl.alu_src_b    = ALU_SRC_B_FOUR;
          ctrl.alu_op_type  = ALU_OP_TYPE_ADD;
          ctrl.pc_source    = PC_SRC_ALU;
          ctrl.ir_write     = ready;
          ctrl.pc_write     = ready;
          ctrl.old_pc_write = ready;
        end
        S_DECODE: begin
          ctrl.reg_a_write   = 1'b1;
          ctrl.reg_b_write   = 1'b1;
          ctrl.alu_out_write = 1'b1;
          ctrl.alu_src_a     = ALU_SRC_A_OLD_PC;
          ctrl.alu_src_b     = ALU_SRC_B_IMM;
          // Speculative branch/JAL target computed while operands are read.
          if (opcode == OPC_BRANCH) begin
            ctrl.imm_src = IMM_TYPE_B;
          end else if (opcode == OPC_JAL) begin
            ctrl.imm_src = IMM_TYPE_J;
          end else begin
            ctrl.imm_src = IMM_TYPE_NONE;
          end
        end
        S_MEM_ADDR: begin
          ctrl.alu_out_write = 1'b1;
          ctrl.alu_src_a     = ALU_SRC_A_REG;
          ctrl.alu_src_b     = ALU_SRC_B_IMM;
          ctrl.imm_src       = (opcode == OPC_LOAD) ? IMM_TYPE_I : IMM_TYPE_S;
        end
        S_MEM_READ: begin
          ctrl.mem_read  = 1'b1;
          ctrl.i_or_d    = 1'b1;
          ctrl.mdr_write = ready;
        end
        S_MEM_WB: begin
          ctrl.reg_write     = 1'b1;
          ctrl.mem_to_reg    = MEM_TO_REG_MDR;
          ctrl.instr_retired = 1'b1;
        end
        S_MEM_WRITE: begin
          ctrl.mem_write     = 1'b1;
          ctrl.i_or_d        = 1'b1;
          ctrl.instr_retired = ready;
        end
        S_EXEC_R: begin
          ctrl.alu_src_a     = ALU_SRC_A_REG;
          ctrl.alu_src_b     = ALU_SRC_B_REG;
          ctrl.alu_op_type   = ALU_OP_TYPE_FUNCT;
          ctrl.alu_out_write = 1'b1;
        end
        S_EXEC_I: begin
          ctrl.alu_src_a     = ALU_SRC_A_REG;
          ctrl.alu_src_b     = ALU_SRC_B_IMM;
          ctrl.imm_src       = IMM_TYPE_I;
          ctrl.alu_op_type   = ALU_OP_TYPE_FUNCT;
          ctrl.alu_out_write = 1'b1;
        end
        S_LUI: begin
          ctrl.alu_src_a     = ALU_SRC_A_ZERO;
          ctrl.alu_src_b     = ALU_SRC_B_IMM;
          ctrl.imm_src       = IMM_TYPE_U;
          ctrl.alu_out_write = 1'b1;
        end
        S_AUIPC: begin
          ctrl.alu_src_a     = ALU_SRC_A_OLD_PC;
          ctrl.alu_src_b     = ALU_SRC_B_IMM;
          ctrl.imm_src       = IMM_TYPE_U;
          ctrl.alu_out_write = 1'b1;
        end
        S_ALU_WB: begin
          ctrl.reg_write     = 1'b1;
          ctrl.mem_to_reg    = MEM_TO_REG_ALU_OUT;
          ctrl.instr_retired = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = ALU_SRC_A_REG;
          ctrl.alu_src_b     = ALU_SRC_B_REG;
          ctrl.alu_op_type   = ALU_OP_TYPE_SUB;
          ctrl.pc_source     = PC_SRC_ALU_OUT;
          ctrl.pc_write      = branch_taken;
          ctrl.instr_retired = 1'b1;
        end
        S_JAL: begin
          // PC already holds the link address from fetch.
          ctrl.reg_write     = 1'b1;
          ctrl.mem_to_reg    = MEM_TO_REG_PC;
          ctrl.pc_write      = 1'b1;
          ctrl.pc_source     = PC_SRC_ALU_OUT;
          ctrl.instr_retired = 1'b1;
        end
        S_JALR: begin
          ctrl.alu_src_a     = ALU_SRC_A_REG;
          ctrl.alu_src_b     = ALU_SRC_B_IMM;
          ctrl.imm_src       = IMM_TYPE_I;
          ctrl.reg_write     = 1'b1;
          ctrl.mem_to_reg    = MEM_TO_REG_PC;
          ctrl.pc_write      = 1'b1;
          ctrl.pc_source     = PC_SRC_ALU_LSB0;
          ctrl.instr_retired = 1'b1;
        end
        S_TRAP: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PC_SRC_TRAP;
          ctrl.trap       = 1'b1;
          ctrl.trap_cause = cause_q;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign old_pc_write  = ctrl.old_pc_write;
  assign ir_write      = ctrl.ir_write;
  assign mdr_write     = ctrl.mdr_write;
  assign reg_a_write   = ctrl.reg_a_write;
  assign reg_b_write   = ctrl.reg_b_write;
  assign alu_out_write = ctrl.alu_out_write;
  assign reg_write     = ctrl.reg_write;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign i_or_d        = ctrl.i_or_d;
  assign pc_source     = ctrl.pc_source;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign imm_src       = ctrl.imm_src;
  assign alu_op_type   = ctrl.alu_op_type;
  assign instr_retired = ctrl.instr_retired;
  assign trap          = ctrl.trap;
  assign trap_cause    = ctrl.trap_cause;
  assign state         = run_q ? state_q : S_FETCH;

endmodule
